// File: rtl/wavelet_pkg.sv
// ---------------------------------------------------------------------------
// wavelet_pkg
// Shared constants for the Haar wavelet filter bank.
//   DEFAULT_DATA_W    default sample/coefficient width
//   DEFAULT_N_LEVELS  default number of cascaded decomposition levels
//   SEL_W             width of the output channel select
//   approx_channel()  select index that routes the final approximation
// ---------------------------------------------------------------------------
package wavelet_pkg;

    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_N_LEVELS = 4;
    localparam int SEL_W            = 8;

    // Channels 0..n_levels-1 are detail outputs; the next index is the
    // approximation, everything above it is the raw passthrough sample.
    function automatic int approx_channel(input int n_levels);
        return n_levels;
    endfunction

endpackage

// File: rtl/haar_stage.sv
// ---------------------------------------------------------------------------
// haar_stage
// One Haar decomposition level. Samples arrive in pairs; the first is held
// in a pending register, the second produces a detail (half difference) and
// an approximation (half sum) coefficient, both registered.
//   clk       system clock
//   rst       asynchronous active-high reset
//   i_valid   one-cycle pulse, i_x carries a new input sample
//   i_x       signed input sample
//   o_detail  registered detail coefficient
//   o_approx  registered approximation coefficient (feeds the next level)
//   o_valid   one-cycle pulse, both outputs were written in the previous cycle
// ---------------------------------------------------------------------------
module haar_stage #(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_x,
    output logic signed [DATA_W-1:0] o_detail,
    output logic signed [DATA_W-1:0] o_approx,
    output logic                     o_valid
);

    logic                     r_phase;
    logic signed [DATA_W-1:0] r_pending;
    logic signed [DATA_W-1:0] r_detail;
    logic signed [DATA_W-1:0] r_approx;
    logic                     r_valid;

    logic signed [DATA_W:0]   w_sum;
    logic signed [DATA_W:0]   w_diff;
    logic signed [DATA_W:0]   w_sum_half;
    logic signed [DATA_W:0]   w_diff_half;

    // One extra bit keeps the full sum/difference; after the arithmetic
    // halving the result always fits back into DATA_W bits.
    assign w_sum       = {r_pending[DATA_W-1], r_pending} + {i_x[DATA_W-1], i_x};
    assign w_diff      = {r_pending[DATA_W-1], r_pending} - {i_x[DATA_W-1], i_x};
    assign w_sum_half  = w_sum >>> 1;
    assign w_diff_half = w_diff >>> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase   <= 1'b0;
            r_pending <= '0;
            r_detail  <= '0;
            r_approx  <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= i_valid & r_phase;
            if (i_valid) begin
                if (!r_phase) begin
                    r_pending <= i_x;
                    r_phase   <= 1'b1;
                end else begin
                    r_detail <= w_diff_half[DATA_W-1:0];
                    r_approx <= w_sum_half[DATA_W-1:0];
                    r_phase  <= 1'b0;
                end
            end
        end
    end

    assign o_detail = r_detail;
    assign o_approx = r_approx;
    assign o_valid  = r_valid;

endmodule

// File: rtl/haar_wavelet_bank.sv
// ---------------------------------------------------------------------------
// haar_wavelet_bank
// Multi-level Haar decomposition of an asynchronously strobed sample stream,
// with one selectable coefficient channel registered to the output.
//   clk                        system clock
//   rst                        asynchronous active-high reset
//   i_data_clk                 asynchronous sample strobe, rising edge = sample
//   i_value                    signed sample, held stable around the strobe
//   i_select_output_channel    0..N_LEVELS-1 detail, N_LEVELS approx,
//                              larger = raw passthrough sample
//   o_multiplexed_wavelet_out  registered selected coefficient
//   o_active                   pulse: output shows a fresh value of the source
// ---------------------------------------------------------------------------
module haar_wavelet_bank
    import wavelet_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int N_LEVELS    = DEFAULT_N_LEVELS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_data_clk,
    input  logic signed [DATA_W-1:0] i_value,
    input  logic [SEL_W-1:0]         i_select_output_channel,
    output logic signed [DATA_W-1:0] o_multiplexed_wavelet_out,
    output logic                     o_active
);

    localparam logic [SEL_W-1:0] APPROX_SEL = SEL_W'(approx_channel(N_LEVELS));

    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_hist;
    logic                     w_strobe;

    logic signed [DATA_W-1:0] r_pass;
    logic                     r_pass_valid;
    logic signed [DATA_W-1:0] r_out;
    logic                     r_active;

    // Level l consumes w_lvl_x[l]/w_lvl_v[l]; entry N_LEVELS is the final
    // approximation register of the last stage.
    logic signed [DATA_W-1:0] w_lvl_x  [N_LEVELS+1];
    logic [N_LEVELS:0]        w_lvl_v;
    logic signed [DATA_W-1:0] w_detail [N_LEVELS];

    logic signed [DATA_W-1:0] w_sel_data;
    logic                     w_sel_fresh;

    // Synchroniser and edge history reset high so a strobe line already high
    // at reset release is not mistaken for a new sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_data_clk};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_strobe = r_sync[SYNC_STAGES-1] & ~r_hist;

    assign w_lvl_x[0] = i_value;
    assign w_lvl_v[0] = w_strobe;

    genvar g;
    generate
        for (g = 0; g < N_LEVELS; g++) begin : g_level
            haar_stage #(
                .DATA_W (DATA_W)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .i_valid  (w_lvl_v[g]),
                .i_x      (w_lvl_x[g]),
                .o_detail (w_detail[g]),
                .o_approx (w_lvl_x[g+1]),
                .o_valid  (w_lvl_v[g+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass       <= '0;
            r_pass_valid <= 1'b0;
        end else begin
            r_pass_valid <= w_strobe;
            if (w_strobe) begin
                r_pass <= i_value;
            end
        end
    end

    always_comb begin
        w_sel_data  = r_pass;
        w_sel_fresh = r_pass_valid;
        if (i_select_output_channel == APPROX_SEL) begin
            w_sel_data  = w_lvl_x[N_LEVELS];
            w_sel_fresh = w_lvl_v[N_LEVELS];
        end else begin
            for (int l = 0; l < N_LEVELS; l++) begin
                if (i_select_output_channel == SEL_W'(l)) begin
                    w_sel_data  = w_detail[l];
                    w_sel_fresh = w_lvl_v[l+1];
                end
            end
        end
    end

    // The fresh flag travels with the data, so switching the select never
    // fabricates an update pulse on its own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out    <= '0;
            r_active <= 1'b0;
        end else begin
            r_out    <= w_sel_data;
            r_active <= w_sel_fresh;
        end
    end

    assign o_multiplexed_wavelet_out = r_out;
    assign o_active                  = r_active;

endmodule

// File: doc/haar_wavelet_bank.md
HAAR_WAVELET_BANK -- requirements
Module: haar_wavelet_bank

Interface
REQ-001 Parameter DATA_W, default 8: sample/coefficient width, signed two's complement.
REQ-002 Parameter N_LEVELS, default 4: number of cascaded Haar decomposition levels, range 1..254.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser depth for i_data_clk, minimum 2.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_data_clk  input  1  asynchronous sample strobe from pad; rising edge = new sample.
REQ-007 i_value  input  DATA_W  signed sample; stable for at least SYNC_STAGES+1 clk cycles after each i_data_clk rise.
REQ-008 i_select_output_channel  input  8  output source select.
REQ-009 o_multiplexed_wavelet_out  output  DATA_W  registered selected coefficient.
REQ-010 o_active  output  1  one-cycle pulse: selected source was freshly updated.

Function
REQ-011 i_data_clk SHALL pass through SYNC_STAGES flops; strobe = one-cycle pulse on synchronised 0->1; call the strobe cycle T.
REQ-012 i_value SHALL be captured in cycle T into level-0 input and into the passthrough register (visible T+1).
REQ-013 Each level l SHALL hold a phase bit and a pending register; input with phase=0 -> store pending, phase<=1, no output.
REQ-014 Input x with phase=1 -> detail = (pending - x) >>> 1, approx = (pending + x) >>> 1, both computed at DATA_W+1 bits, arithmetic shift (floor), truncated to DATA_W; phase<=0.
REQ-015 Detail of level l SHALL be written to detail_reg[l]; approx SHALL be registered and presented to level l+1 one cycle later.
REQ-016 Latency: level-l completing pair from strobe T SHALL be visible at T+1+l; approx of level N_LEVELS-1 goes to approx_reg, visible at T+N_LEVELS.
REQ-017 Select mapping: 0..N_LEVELS-1 -> detail_reg[sel]; N_LEVELS -> approx_reg; any larger value -> passthrough register.
REQ-018 o_multiplexed_wavelet_out SHALL be re-registered every cycle from the selected source: 1-cycle latency after a source or select change.
REQ-019 o_active SHALL be high in the cycle o_multiplexed_wavelet_out first shows a newly written value of the currently selected source; a select change alone SHALL NOT pulse it.
REQ-020 Back-to-back strobes at the maximum synchronised rate (one per 2 clk cycles) SHALL be accepted without loss; levels never stall.
REQ-021 Level l SHALL emit one coefficient per 2^(l+1) input samples; approx_reg updates once per 2^N_LEVELS samples.
REQ-022 No overflow is possible: (DATA_W+1)-bit sum/difference shifted by 1 always fits DATA_W.

Reset
REQ-023 rst SHALL asynchronously clear all phase bits, pending, detail, approx, passthrough and output registers to 0 and o_active to 0.
REQ-024 Synchroniser flops and edge-history flop SHALL reset to 1, so i_data_clk held high across reset release produces no strobe.
REQ-025 rst mid-operation SHALL discard all unpaired samples; first post-reset sample starts at phase 0 on every level.

Structure
REQ-026 Shared package wavelet_pkg SHALL hold default DATA_W/N_LEVELS, the select-width constant (8) and a function returning the approx channel index (=N_LEVELS).
REQ-027 One sub-module haar_stage (phase, pending, detail, approx-out registers, valid in/out) SHALL be instantiated N_LEVELS times in a generate loop.

Verification (DATA_W=8, N_LEVELS=4)
REQ-028 sel=0, samples 10 then 6 -> output 2 (0x02) at T+2 of second strobe, o_active pulse same cycle; level-1 pending holds 8.
REQ-029 sel=4, 16 samples of 20 -> output 20 at T+5 of 16th strobe with one o_active pulse; sel=0..3 then read 0.
REQ-030 sel=0, samples -3 then 0 -> output 0xFE (-2); samples 127 then -128 -> output 127 (0x7F), level-1 input -1.
REQ-031 sel=5, sample 0x5A -> output 0x5A at T+2, o_active pulse; changing sel to 0 afterwards -> no o_active pulse.
REQ-032 Sample 50, assert rst 3 cycles, then samples 10,6 with sel=0 -> output 0 during/after reset, then 2; 50 never contributes.
REQ-033 i_data_clk held high through rst deassertion for 20 cycles -> o_active stays 0, all outputs 0.
